// File: rtl/sa_compute_sequencer.sv
// Sequences one matrix-multiply job on the systolic array: optional accumulator clear,
// K operand-slice reads, per-lane skew onto the west/north edges, drain, then done handshake.
module sa_compute_sequencer #(
  parameter int ARRAY_N = 4,
  parameter int DATA_W  = 8,
  parameter int K_MAX   = 8,
  parameter int ADDR_W  = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_compute,
  input  logic [4:0]                instruction_i,
  output logic                      rd_en,
  output logic [ADDR_W-1:0]         rd_addr,
  input  logic [ARRAY_N*DATA_W-1:0] a_rd_data,
  input  logic [ARRAY_N*DATA_W-1:0] b_rd_data,
  output logic [ARRAY_N*DATA_W-1:0] west_o,
  output logic [ARRAY_N*DATA_W-1:0] north_o,
  output logic [ARRAY_N-1:0]        west_valid_o,
  output logic [ARRAY_N-1:0]        north_valid_o,
  output logic                      pe_clear,
  output logic                      busy,
  output logic                      systolic_array_done
);

  localparam int DRAIN_CYC = 2 * ARRAY_N;
  localparam int CNT_MAX   = (K_MAX > DRAIN_CYC) ? K_MAX : DRAIN_CYC;
  localparam int CNT_W     = $clog2(CNT_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       k_last_q, k_last_d;
  logic             done_q;
  logic             rd_valid_q;
  logic             abort;

  // Bit 4 of the descriptor carries no meaning for this block.
  logic unused_instr_bit;
  assign unused_instr_bit = instruction_i[4];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      k_last_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      k_last_q <= k_last_d;
      done_q   <= (state_d == S_DONE);
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    k_last_d = k_last_q;
    case (state_q)
      S_IDLE: begin
        if (start_compute) begin
          k_last_d = instruction_i[2:0];
          cnt_d    = '0;
          state_d  = instruction_i[3] ? S_FEED : S_CLEAR;
        end
      end
      S_CLEAR: begin
        cnt_d   = '0;
        state_d = start_compute ? S_FEED : S_IDLE;
      end
      S_FEED: begin
        if (!start_compute) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_W'(k_last_q)) begin
          cnt_d   = '0;
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (!start_compute) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_W'(DRAIN_CYC - 1)) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        if (!start_compute) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy                = (state_q == S_CLEAR) || (state_q == S_FEED) || (state_q == S_DRAIN);
  assign abort               = busy && !start_compute;
  assign pe_clear            = (state_q == S_CLEAR);
  assign rd_en               = (state_q == S_FEED) && start_compute;
  assign rd_addr             = rd_en ? ADDR_W'(cnt_q) : '0;
  assign systolic_array_done = done_q;

  // Buffer data lags rd_en by one cycle; this flag qualifies it at the skew input.
  always_ff @(posedge clk) begin
    if (rst || abort) rd_valid_q <= 1'b0;
    else              rd_valid_q <= rd_en;
  end

  // Lane gi of each edge sees gi extra register stages; invalid slots carry zeros.
  genvar gi;
  generate
    for (gi = 0; gi < ARRAY_N; gi++) begin : g_lane
      logic [DATA_W-1:0] a_in;
      logic [DATA_W-1:0] b_in;
      assign a_in = rd_valid_q ? a_rd_data[gi*DATA_W +: DATA_W] : '0;
      assign b_in = rd_valid_q ? b_rd_data[gi*DATA_W +: DATA_W] : '0;

      if (gi == 0) begin : g_direct
        assign west_o[gi*DATA_W +: DATA_W]  = a_in;
        assign north_o[gi*DATA_W +: DATA_W] = b_in;
        assign west_valid_o[gi]             = rd_valid_q;
        assign north_valid_o[gi]            = rd_valid_q;
      end else begin : g_delay
        logic [DATA_W-1:0] a_q [gi];
        logic [DATA_W-1:0] b_q [gi];
        logic              v_q [gi];

        always_ff @(posedge clk) begin
          if (rst || abort) begin
            for (int s = 0; s < gi; s++) begin
              a_q[s] <= '0;
              b_q[s] <= '0;
              v_q[s] <= 1'b0;
            end
          end else begin
            a_q[0] <= a_in;
            b_q[0] <= b_in;
            v_q[0] <= rd_valid_q;
            for (int s = 1; s < gi; s++) begin
              a_q[s] <= a_q[s-1];
              b_q[s] <= b_q[s-1];
              v_q[s] <= v_q[s-1];
            end
          end
        end

        assign west_o[gi*DATA_W +: DATA_W]  = a_q[gi-1];
        assign north_o[gi*DATA_W +: DATA_W] = b_q[gi-1];
        assign west_valid_o[gi]             = v_q[gi-1];
        assign north_valid_o[gi]            = v_q[gi-1];
      end
    end
  endgenerate

endmodule
